// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one 32-bit add/subtract datapath between NREQ requesters.
//   A round-robin arbiter grants one requester while the block is idle;
//   its operands are latched, the sum/difference and flags are computed
//   in one EXEC cycle, and the registered result is held on a
//   valid/ready response channel tagged with the requester index.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[NREQ]       per-requester request
//   req_sub[NREQ]         1 = a-b, 0 = a+b
//   req_a/req_b[NREQ*32]  operands, requester i at [32i+31:32i]
//   req_ready[NREQ]       one-hot grant (combinational, IDLE only)
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                index of the requester owning the result
//   rsp_sum               result modulo 2^32
//   rsp_carry             carry-out (add) / no-borrow (subtract)
//   rsp_ovf               two's-complement overflow
//   busy                  high while an operation is in flight (EXEC/RESP)
module adder_arbiter #(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_sub,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_sum,
    output logic              rsp_carry,
    output logic              rsp_ovf,
    input  logic              rsp_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [31:0]    a;
        logic [31:0]    b;
        logic           sub;
        logic [IDW-1:0] id;
    } op_t;

    state_t         state;
    op_t            op;
    logic [IDW-1:0] last;

    // Round-robin pick: scan from last+1 upward with wrap, first hit wins.
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (state == IDLE) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!gnt_any && req_valid[(int'(last) + k) % NREQ]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDW'((int'(last) + k) % NREQ);
                end
            end
        end
        req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    end

    // Subtract is A + ~B + 1, so carry-out doubles as "no borrow".
    logic [31:0] bop;
    logic [32:0] wsum;
    logic        ovf;

    always_comb begin
        bop  = op.sub ? ~op.b : op.b;
        wsum = {1'b0, op.a} + {1'b0, bop} + {32'b0, op.sub};
        ovf  = (op.a[31] == bop[31]) && (wsum[31] != op.a[31]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IDW'(NREQ - 1);
            op        <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A grant is itself the handshake: req_ready is only
                    // raised for a requester that has req_valid high.
                    if (gnt_any) begin
                        op.a   <= req_a[32*int'(gnt_idx) +: 32];
                        op.b   <= req_b[32*int'(gnt_idx) +: 32];
                        op.sub <= req_sub[gnt_idx];
                        op.id  <= gnt_idx;
                        last   <= gnt_idx;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= wsum[31:0];
                    rsp_carry <= wsum[32];
                    rsp_ovf   <= ovf;
                    rsp_id    <= op.id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // rsp_* data stays put after the handshake; only
                    // rsp_valid qualifies it.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
